// File: rtl/lcd_cmd_sched.sv
// Two-requester command scheduler and FIFO feeding the LCD driver over a start/busy handshake.
// Define LCD_SCHED_PRIO_EN for fixed priority (requester 0 wins); default build is round robin.
module lcd_cmd_sched #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_TO    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [23:0]   cmd0,
  output logic          ack0,
  input  logic          req1,
  input  logic [23:0]   cmd1,
  output logic          ack1,
  output logic [7:0]    addr_out,
  output logic [7:0]    ctrl_out,
  output logic [7:0]    data_out,
  output logic          lcd_start,
  input  logic          lcd_busy,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   level,
  output logic          to_err
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]  GAP_L    = 8'(GAP_CYCLES);
  localparam logic [7:0]  BUSY_L   = 8'(BUSY_TO);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic          to_err_q, to_err_d;
  logic [23:0]   out_q, out_d;
  logic          elig0, elig1, grant0, grant1, wr_en, pop, full, empty;
  logic [23:0]   wr_data;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // Write-side arbitration; an ack in flight masks its requester so one command is never written twice.
`ifdef LCD_SCHED_PRIO_EN
  always_comb begin
    elig0  = req0 & ~ack0_q;
    elig1  = req1 & ~ack1_q;
    grant0 = ~full & elig0;
    grant1 = ~full & elig1 & ~elig0;
  end
`else
  logic rr_q, rr_d;

  always_comb begin
    elig0  = req0 & ~ack0_q;
    elig1  = req1 & ~ack1_q;
    grant0 = ~full & elig0 & (~elig1 | ~rr_q);
    grant1 = ~full & elig1 & (~elig0 | rr_q);
    rr_d   = rr_q;
    if (grant0)      rr_d = 1'b1;
    else if (grant1) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    wr_en    = grant0 | grant1;
    wr_data  = grant1 ? cmd1 : cmd0;
    ack0_d   = grant0;
    ack1_d   = grant1;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop)      level_d = level_q + 1'b1;
    else if (!wr_en && pop) level_d = level_q - 1'b1;
  end

  // Entry storage carries no reset: level and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      to_err_q  <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      to_err_q  <= to_err_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    to_err_d  = to_err_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && !lcd_busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (lcd_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_d == BUSY_L) begin
            to_err_d = 1'b1;
            state_d  = S_GAP;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!lcd_busy) begin
          gap_cnt_d = GAP_L;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The head is latched on entry to ISSUE so the outputs are valid alongside lcd_start.
  always_comb begin
    pop       = (state_q == S_ISSUE);
    lcd_start = (state_q == S_ISSUE);
    out_d     = out_q;
    if (state_q == S_IDLE && state_d == S_ISSUE) out_d = mem_q[rd_ptr_q];
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign addr_out   = out_q[23:16];
  assign ctrl_out   = out_q[15:8];
  assign data_out   = out_q[7:0];
  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign level      = level_q;
  assign to_err     = to_err_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: vector table for single commands plus hand-written
// sequences for contention, full FIFO, handshake spacing, busy timeout and mid-flight reset.
module tb_lcd_cmd_sched;
  localparam int DEPTH = 8, AW = 3, GAP_CYCLES = 16, BUSY_TO = 15;

  typedef struct {
    bit          sel;
    logic [23:0] cmd;
    logic [7:0]  ea;
    logic [7:0]  ec;
    logic [7:0]  ed;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] cmd0 = '0, cmd1 = '0;
  logic        ack0, ack1, lcd_start, fifo_full, fifo_empty, to_err;
  logic [7:0]  addr_out, ctrl_out, data_out;
  logic [AW:0] level;
  logic        resp_busy = 1'b0, stuck_busy = 1'b0;
  logic        lcd_busy;

  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, n_starts = 0, last_start = -1, prev_start = -1;
  bit          resp_en = 1'b1;
  int          resp_len = 3;
  logic [23:0] exp_q[$];

  assign lcd_busy = resp_busy | stuck_busy;

  lcd_cmd_sched #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP_CYCLES), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .ack1(ack1),
    .addr_out(addr_out), .ctrl_out(ctrl_out), .data_out(data_out),
    .lcd_start(lcd_start), .lcd_busy(lcd_busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level), .to_err(to_err)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (fifo_empty !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check("drain_empty_in_time", fifo_empty, 1);
    repeat (30) tick();
    check("drain_sb_all_issued", exp_q.size(), 0);
  endtask

  // scoreboard: every lcd_start must present the oldest accepted command
  initial begin : sb_mon
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (lcd_start === 1'b1) begin
        n_starts++;
        prev_start = last_start;
        last_start = cyc;
        check("sb_start_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_cmd", {8'h0, addr_out, ctrl_out, data_out}, {8'h0, e});
        end
      end
    end
  end

  // LCD driver model: busy rises the cycle after lcd_start and stays high resp_len cycles
  initial begin : lcd_model
    forever begin
      @(negedge clk);
      if (resp_en && lcd_start === 1'b1) begin
        @(posedge clk);
        #1 resp_busy = 1'b1;
        repeat (resp_len) @(posedge clk);
        #1 resp_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    vec_t vecs[4];
    int   order[$];
    int   idx0, idx1, k, seen, base, t_wait;
    logic [23:0] c0s[2];
    logic [23:0] c1s[2];

    vecs[0] = '{1'b0, 24'h123456, 8'h12, 8'h34, 8'h56};
    vecs[1] = '{1'b1, 24'hA50FC3, 8'hA5, 8'h0F, 8'hC3};
    vecs[2] = '{1'b0, 24'hFF00FF, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 24'h008001, 8'h00, 8'h80, 8'h01};

    // reset state
    repeat (3) tick();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_addr", addr_out, 0);
    check("rst_ctrl", ctrl_out, 0);
    check("rst_data", data_out, 0);
    check("rst_start", lcd_start, 0);
    check("rst_full", fifo_full, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_level", level, 0);
    check("rst_to_err", to_err, 0);
    rst = 1'b0;
    tick();

    // table: single command latency and field mapping
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].sel == 1'b0) begin req0 = 1'b1; cmd0 = vecs[i].cmd; end
      else                     begin req1 = 1'b1; cmd1 = vecs[i].cmd; end
      tick();
      check("vec_ack_sel", vecs[i].sel ? ack1 : ack0, 1);
      check("vec_ack_other", vecs[i].sel ? ack0 : ack1, 0);
      check("vec_level", level, 1);
      check("vec_empty", fifo_empty, 0);
      check("vec_start_early", lcd_start, 0);
      exp_q.push_back(vecs[i].cmd);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check("vec_ack_pulse_width", vecs[i].sel ? ack1 : ack0, 0);
      check("vec_start", lcd_start, 1);
      check("vec_addr", addr_out, vecs[i].ea);
      check("vec_ctrl", ctrl_out, vecs[i].ec);
      check("vec_data", data_out, vecs[i].ed);
      drain();
    end

    // contention: both requesters held for two commands each
    c0s[0] = 24'hA00001; c0s[1] = 24'hA00002;
    c1s[0] = 24'hB10001; c1s[1] = 24'hB10002;
    idx0 = 0; idx1 = 0;
    req0 = 1'b1; cmd0 = c0s[0];
    req1 = 1'b1; cmd1 = c1s[0];
    k = 0;
    while ((idx0 < 2 || idx1 < 2) && k < 12) begin
      tick();
      k++;
      check("cont_single_ack", ack0 & ack1, 0);
      if (ack0) begin
        order.push_back(0);
        exp_q.push_back(cmd0);
        idx0++;
        if (idx0 < 2) cmd0 = c0s[idx0]; else req0 = 1'b0;
      end
      if (ack1) begin
        order.push_back(1);
        exp_q.push_back(cmd1);
        idx1++;
        if (idx1 < 2) cmd1 = c1s[idx1]; else req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("cont_grant_count", order.size(), 4);
    for (int j = 0; j < order.size() && j < 4; j++)
      check("cont_grant_order", order[j], j % 2);
    drain();

    // round-robin pointer: after a lone grant to 0, a simultaneous request goes to 1 first
    req0 = 1'b1; cmd0 = 24'h0C0C0C;
    tick();
    check("rr_lone_ack0", ack0, 1);
    exp_q.push_back(cmd0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; cmd0 = 24'h0D0D0D;
    req1 = 1'b1; cmd1 = 24'h1D1D1D;
    tick();
`ifdef LCD_SCHED_PRIO_EN
    check("rr_first_ack0", ack0, 1);
    check("rr_first_ack1", ack1, 0);
    exp_q.push_back(cmd0);
    req0 = 1'b0;
    tick();
    check("rr_second_ack1", ack1, 1);
    exp_q.push_back(cmd1);
    req1 = 1'b0;
`else
    check("rr_first_ack1", ack1, 1);
    check("rr_first_ack0", ack0, 0);
    exp_q.push_back(cmd1);
    req1 = 1'b0;
    tick();
    check("rr_second_ack0", ack0, 1);
    exp_q.push_back(cmd0);
    req0 = 1'b0;
`endif
    drain();

    // full: busy stuck high so nothing drains; the ninth push must wait for a pop
    stuck_busy = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      req0 = 1'b1;
      cmd0 = 24'hF00000 | 24'(j);
      tick();
      check("full_push_ack", ack0, 1);
      exp_q.push_back(cmd0);
      req0 = 1'b0;
      tick();
    end
    check("full_level", level, 8);
    check("full_flag", fifo_full, 1);
    check("full_not_empty", fifo_empty, 0);
    req0 = 1'b1;
    cmd0 = 24'hF00009;
    seen = 0;
    repeat (6) begin
      tick();
      if (ack0) seen++;
    end
    check("full_ninth_blocked", seen, 0);
    check("full_level_held", level, 8);
    stuck_busy = 1'b0;
    seen = 0;
    k = 0;
    while (!seen && k < 10) begin
      tick();
      k++;
      if (ack0) seen = 1;
    end
    check("full_ninth_after_pop", seen, 1);
    exp_q.push_back(cmd0);
    req0 = 1'b0;
    drain();

    // handshake spacing: busy 5 cycles, two queued commands
    resp_len = 5;
    base = n_starts;
    req0 = 1'b1; cmd0 = 24'h515151;
    tick();
    check("space_ack0", ack0, 1);
    exp_q.push_back(cmd0);
    req0 = 1'b0;
    req1 = 1'b1; cmd1 = 24'h525252;
    tick();
    check("space_ack1", ack1, 1);
    exp_q.push_back(cmd1);
    req1 = 1'b0;
    k = 0;
    while (n_starts < base + 2 && k < 100) begin
      tick();
      k++;
    end
    check("space_two_starts", n_starts - base, 2);
    check("space_period", last_start - prev_start, 25);
    drain();
    resp_len = 3;

    // busy timeout: driver never answers
    resp_en = 1'b0;
    check("to_err_clear_before", to_err, 0);
    req0 = 1'b1; cmd0 = 24'h7E7E7E;
    tick();
    exp_q.push_back(cmd0);
    req0 = 1'b0;
    req1 = 1'b1; cmd1 = 24'h7F7F7F;
    tick();
    check("to_second_ack", ack1, 1);
    exp_q.push_back(cmd1);
    req1 = 1'b0;
    // first lcd_start sits in the cycle where cmd1's ack is visible
    check("to_first_start", lcd_start, 1);
    repeat (15) tick();
    check("to_err_not_yet", to_err, 0);
    tick();
    check("to_err_set", to_err, 1);
    t_wait = 0;
    while (lcd_start !== 1'b1 && t_wait < 20) begin
      tick();
      t_wait++;
    end
    check("to_next_start_delay", t_wait, 2);
    drain();
    check("to_err_sticky", to_err, 1);
    resp_en = 1'b1;

    // reset mid-flight: one command in WAIT_DONE, three queued
    resp_len = 40;
    req0 = 1'b1; cmd0 = 24'hC1C1C1;
    tick();
    exp_q.push_back(cmd0);
    req0 = 1'b0;
    req1 = 1'b1; cmd1 = 24'hC2C2C2;
    tick();
    check("mid_ack_b", ack1, 1);
    req1 = 1'b0;
    req0 = 1'b1; cmd0 = 24'hC3C3C3;
    tick();
    check("mid_ack_c", ack0, 1);
    req0 = 1'b0;
    req1 = 1'b1; cmd1 = 24'hC4C4C4;
    tick();
    check("mid_ack_d", ack1, 1);
    req1 = 1'b0;
    tick();
    check("mid_level_before", level, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_full", fifo_full, 0);
    check("mid_rst_addr", addr_out, 0);
    check("mid_rst_ctrl", ctrl_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_start", lcd_start, 0);
    check("mid_rst_ack", {ack0, ack1}, 0);
    check("mid_rst_to_err", to_err, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    base = n_starts;
    seen = 0;
    repeat (80) begin
      tick();
      if (ack0 || ack1) seen++;
    end
    check("mid_no_start_after", n_starts - base, 0);
    check("mid_no_ack_after", seen, 0);
    check("mid_level_after", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
